inst_packer: RTL and testbench
==============================

# inst_packer

Instruction encoder and program loader: the inverse of immediate decoding. Accepts decoded instruction fields plus a full 32-bit immediate over a valid/ready handshake. Packs them into a 32-bit RV32I word using the same 3-bit format select as the decode-side immediate generator, range-checks the immediate, and writes the word to instruction memory at an auto-incrementing word address. Used for self-test program loading and for boot-time stub generation in front of IMEM.

## Interface
- ADDR_W, 11, IMEM word-address width
- BASE_ADDR, 0, first write address after reset or `i_start`
- i_clk  in  1  clock; all state updates on the rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_start  in  1  restart load: address to BASE_ADDR, count and error cleared
- i_req_valid  in  1  request valid
- o_req_ready  out  1  request ready; equals (state==S_IDLE) & ~i_start
- i_imm_sel  in  3  format select: 0 I, 1 I-shamt, 2 S, 3 B, 4 U, 5 J, 6 R, 7 reserved
- i_opcode  in  7  opcode field
- i_funct3  in  3  funct3 field
- i_funct7  in  7  funct7 field
- i_rd  in  5  rd field
- i_rs1  in  5  rs1 field
- i_rs2  in  5  rs2 field
- i_imm  in  32  immediate, full-width signed byte offset / value
- o_wr_en  out  1  IMEM write strobe, held until accepted
- o_wr_addr  out  ADDR_W  IMEM word address
- o_wr_data  out  32  packed instruction
- i_wr_ready  in  1  IMEM accepts the write this cycle
- o_count  out  ADDR_W+1  words written since start; saturates at 2^ADDR_W
- o_err  out  1  sticky immediate-range / reserved-format error
- o_err_addr  out  ADDR_W  address of the first erroneous word
- o_busy  out  1  state != S_IDLE

## Operation
- FSM states:
  - S_IDLE: ready; handshake (valid & ready) captures all fields and moves to S_PACK.
  - S_PACK: packs the word, runs the range check, and registers o_wr_data; moves to S_WRITE.
  - S_WRITE: o_wr_en=1; when i_wr_ready=1, o_wr_addr increments, o_count increments (saturating), and the FSM returns to S_IDLE.
- Packing by format:
  - I: {imm[11:0], rs1, f3, rd, op}
  - I-shamt: {f7, imm[4:0], rs1, f3, rd, op}
  - S: {imm[11:5], rs2, rs1, f3, imm[4:0], op}
  - B: {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op}
  - U: {imm[31:12], rd, op}
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}
  - R: {f7, rs2, rs1, f3, rd, op}
  - reserved: NOP 0x00000013
- Range rules (fail when violated):
  - I and S: imm[31:11] all equal.
  - I-shamt: imm[31:5]==0.
  - B: imm[31:12] all equal and imm[0]==0.
  - U: imm[11:0]==0.
  - J: imm[31:20] all equal and imm[0]==0.
  - R: never fails.
  - Reserved: always fails.
- A failing word is still written, truncated. o_err is set, and o_err_addr latches the address only if o_err was 0.
- Address wraps from 2^ADDR_W−1 to 0; o_count holds at 2^ADDR_W.
- i_start in any state:
  - The in-flight request is dropped with no write.
  - FSM goes to S_IDLE.
  - o_wr_addr=BASE_ADDR, o_count=0, o_err=0, o_err_addr=0.
  - i_start has priority over a same-cycle handshake; that request is not accepted.

## Timing
- Reset values: o_req_ready=1, o_wr_en=0, o_wr_addr=BASE_ADDR, o_wr_data=0, o_count=0, o_err=0, o_err_addr=0, o_busy=0.
- Handshake at edge N: o_wr_en is high from cycle N+2.
- With i_wr_ready held high, throughput is one word per 3 cycles.
- While o_wr_en=1 and i_wr_ready=0, o_wr_addr and o_wr_data are stable.
- o_err becomes visible in the same cycle o_wr_en first rises.
- Reset asserted mid-operation: outputs go to their reset values asynchronously; no partial write is allowed.

## Configuration
- INST_PACKER_RANGE_CHECK_EN defined: range checking and o_err/o_err_addr behave as above.
- Undefined: no checking; immediates are silently truncated, and o_err and o_err_addr are tied 0. The reserved format still packs as NOP.

## Structure
- Shared package `riscv_pkg` holds:
  - the imm_sel enum, shared with the decode-side immediate generator so encodings never diverge;
  - the NOP constant;
  - the FSM state enum.
- One combinational sub-module, `inst_pack_comb`, does the fields→word packing and the range-fail flag; the top module holds the FSM, counters and output registers.

## Test plan
- I, op=0x13, rd=1, rs1=0, f3=0, imm=5 → 0x00500093 written at addr 0 on cycle N+2; o_count=1.
- S, op=0x23, f3=2, rs1=3, rs2=2, imm=0xFFFFFFFC → 0xFE21AE23 at addr 1.
- J, op=0x6F, rd=1, imm=8 → 0x008000EF; then I with imm=2048 → 0x80000093 written, o_err=1, o_err_addr=that address. Without the macro, o_err stays 0.
- Backpressure: i_wr_ready=0 for 3 cycles → o_wr_en, addr and data stable, o_req_ready=0; one write commits and addr increments exactly once.
- ADDR_W=2, 5 back-to-back requests → addresses 0,1,2,3,0; o_count ends at 4.
- i_start asserted during S_WRITE with i_wr_ready=0 → no write commits; next request writes at BASE_ADDR with o_count=1.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I encode/decode definitions: immediate format select, NOP word,
// packer FSM states and the captured request bundle.
package riscv_pkg;

  typedef enum logic [2:0] {
    ImmI      = 3'd0,
    ImmIShamt = 3'd1,
    ImmS      = 3'd2,
    ImmB      = 3'd3,
    ImmU      = 3'd4,
    ImmJ      = 3'd5,
    ImmR      = 3'd6,
    ImmRsvd   = 3'd7
  } imm_sel_e;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef logic [1:0] state_t;
  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_PACK  = 2'd1;
  localparam state_t S_WRITE = 2'd2;

  typedef struct packed {
    imm_sel_e    sel;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } inst_fields_t;

endpackage

// File: rtl/inst_pack_comb.sv
// Combinational RV32I field packer and immediate range check.
// Range checking only when INST_PACKER_RANGE_CHECK_EN is defined.
module inst_pack_comb
  import riscv_pkg::*;
(
  input  inst_fields_t fields_i,
  output logic [31:0]  word_o,
  output logic         range_fail_o
);

  logic [31:0] imm;
  logic [6:0]  op;
  assign imm = fields_i.imm;
  assign op  = fields_i.opcode;

  always_comb begin
    word_o = NOP;
    unique case (fields_i.sel)
      ImmI:      word_o = {imm[11:0], fields_i.rs1, fields_i.funct3, fields_i.rd, op};
      ImmIShamt: word_o = {fields_i.funct7, imm[4:0], fields_i.rs1, fields_i.funct3,
                           fields_i.rd, op};
      ImmS:      word_o = {imm[11:5], fields_i.rs2, fields_i.rs1, fields_i.funct3,
                           imm[4:0], op};
      ImmB:      word_o = {imm[12], imm[10:5], fields_i.rs2, fields_i.rs1, fields_i.funct3,
                           imm[4:1], imm[11], op};
      ImmU:      word_o = {imm[31:12], fields_i.rd, op};
      ImmJ:      word_o = {imm[20], imm[10:1], imm[11], imm[19:12], fields_i.rd, op};
      ImmR:      word_o = {fields_i.funct7, fields_i.rs2, fields_i.rs1, fields_i.funct3,
                           fields_i.rd, op};
      ImmRsvd:   word_o = NOP;
      default:   word_o = NOP;
    endcase
  end

`ifdef INST_PACKER_RANGE_CHECK_EN
  // "All equal" means the upper bits are a clean sign extension.
  logic sext_11, sext_12, sext_20;
  assign sext_11 = (&imm[31:11]) | ~(|imm[31:11]);
  assign sext_12 = (&imm[31:12]) | ~(|imm[31:12]);
  assign sext_20 = (&imm[31:20]) | ~(|imm[31:20]);

  always_comb begin
    range_fail_o = 1'b0;
    unique case (fields_i.sel)
      ImmI, ImmS: range_fail_o = ~sext_11;
      ImmIShamt:  range_fail_o = |imm[31:5];
      ImmB:       range_fail_o = ~sext_12 | imm[0];
      ImmU:       range_fail_o = |imm[11:0];
      ImmJ:       range_fail_o = ~sext_20 | imm[0];
      ImmR:       range_fail_o = 1'b0;
      ImmRsvd:    range_fail_o = 1'b1;
      default:    range_fail_o = 1'b1;
    endcase
  end
`else
  assign range_fail_o = 1'b0;
`endif

endmodule

// File: rtl/inst_packer.sv
// Instruction encoder / IMEM program loader: IDLE -> PACK -> WRITE per word.
// Error reporting depends on INST_PACKER_RANGE_CHECK_EN (else o_err/o_err_addr stay 0).
module inst_packer
  import riscv_pkg::*;
#(
  parameter int unsigned ADDR_W    = 11,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [2:0]        i_imm_sel,
  input  logic [6:0]        i_opcode,
  input  logic [2:0]        i_funct3,
  input  logic [6:0]        i_funct7,
  input  logic [4:0]        i_rd,
  input  logic [4:0]        i_rs1,
  input  logic [4:0]        i_rs2,
  input  logic [31:0]       i_imm,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [31:0]       o_wr_data,
  input  logic              i_wr_ready,
  output logic [ADDR_W:0]   o_count,
  output logic              o_err,
  output logic [ADDR_W-1:0] o_err_addr,
  output logic              o_busy
);

  localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   CountMax = {1'b1, {ADDR_W{1'b0}}};

  state_t              state_q, state_d;
  inst_fields_t        fields_q;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [31:0]         data_q, data_d;
  logic                err_q, err_d;
  logic [ADDR_W-1:0]   err_addr_q, err_addr_d;
  logic                accept;
  logic [31:0]         pack_word;
  logic                pack_fail;

  inst_pack_comb u_pack (
    .fields_i     (fields_q),
    .word_o       (pack_word),
    .range_fail_o (pack_fail)
  );

  assign o_req_ready = (state_q == S_IDLE) & ~i_start;
  assign accept      = o_req_ready & i_req_valid;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    count_d    = count_q;
    data_d     = data_q;
    err_d      = err_q;
    err_addr_d = err_addr_q;
    if (i_start) begin
      // Restart drops any in-flight word; wr_data is left as-is, wr_en deasserts.
      state_d    = S_IDLE;
      addr_d     = BaseAddr;
      count_d    = '0;
      err_d      = 1'b0;
      err_addr_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_req_valid) state_d = S_PACK;
        end
        S_PACK: begin
          data_d  = pack_word;
          state_d = S_WRITE;
          if (pack_fail) begin
            err_d = 1'b1;
            if (!err_q) err_addr_d = addr_q;
          end
        end
        S_WRITE: begin
          if (i_wr_ready) begin
            addr_d  = addr_q + 1'b1;
            state_d = S_IDLE;
            if (count_q != CountMax) count_d = count_q + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= BaseAddr;
      count_q    <= '0;
      data_q     <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      data_q     <= data_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fields_q <= '0;
    end else if (accept) begin
      fields_q <= '{sel:    imm_sel_e'(i_imm_sel),
                    opcode: i_opcode,
                    funct3: i_funct3,
                    funct7: i_funct7,
                    rd:     i_rd,
                    rs1:    i_rs1,
                    rs2:    i_rs2,
                    imm:    i_imm};
    end
  end

  assign o_wr_en    = (state_q == S_WRITE);
  assign o_wr_addr  = addr_q;
  assign o_wr_data  = data_q;
  assign o_count    = count_q;
  assign o_err      = err_q;
  assign o_err_addr = err_addr_q;
  assign o_busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_inst_packer.sv
// Directed self-checking bench for inst_packer; a second ADDR_W=2 instance
// shares the stimulus and is used for the address-wrap / count-saturation test.
module tb_inst_packer;

`ifdef INST_PACKER_RANGE_CHECK_EN
  localparam bit ChkEn = 1'b1;
`else
  localparam bit ChkEn = 1'b0;
`endif

  logic        clk, rst_n, start, req_valid, wr_ready;
  logic [2:0]  imm_sel, funct3;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm;

  logic        req_ready, wr_en, err, busy;
  logic [10:0] wr_addr, err_addr;
  logic [31:0] wr_data;
  logic [11:0] count;

  logic        s_req_ready, s_wr_en, s_err, s_busy;
  logic [1:0]  s_wr_addr, s_err_addr;
  logic [31:0] s_wr_data;
  logic [2:0]  s_count;

  int tests = 0;
  int fails = 0;

  inst_packer #(.ADDR_W(11), .BASE_ADDR(0)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_req_valid(req_valid),
    .o_req_ready(req_ready), .i_imm_sel(imm_sel), .i_opcode(opcode), .i_funct3(funct3),
    .i_funct7(funct7), .i_rd(rd), .i_rs1(rs1), .i_rs2(rs2), .i_imm(imm),
    .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_wr_data(wr_data), .i_wr_ready(wr_ready),
    .o_count(count), .o_err(err), .o_err_addr(err_addr), .o_busy(busy)
  );

  inst_packer #(.ADDR_W(2), .BASE_ADDR(0)) dut_small (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_req_valid(req_valid),
    .o_req_ready(s_req_ready), .i_imm_sel(imm_sel), .i_opcode(opcode), .i_funct3(funct3),
    .i_funct7(funct7), .i_rd(rd), .i_rs1(rs1), .i_rs2(rs2), .i_imm(imm),
    .o_wr_en(s_wr_en), .o_wr_addr(s_wr_addr), .o_wr_data(s_wr_data), .i_wr_ready(wr_ready),
    .o_count(s_count), .o_err(s_err), .o_err_addr(s_err_addr), .o_busy(s_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Handshake at a posedge, then return at the negedge where wr_en should first be high.
  task automatic issue(input logic [2:0] sel, input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [4:0] d, input logic [4:0] s1,
                       input logic [4:0] s2, input logic [31:0] im);
    @(negedge clk);
    imm_sel = sel; opcode = op; funct3 = f3; funct7 = f7;
    rd = d; rs1 = s1; rs2 = s2; imm = im;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    tests++;
    if (wr_en !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL pack_phase: wr_en=%b busy=%b required wr_en=0 busy=1", wr_en, busy);
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    tests++;
    if (req_ready !== 1'b1 || wr_en !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctrl: ready=%b wr_en=%b busy=%b required 1 0 0",
               req_ready, wr_en, busy);
    end
    tests++;
    if (wr_addr !== 11'd0 || wr_data !== 32'd0 || count !== 12'd0) begin
      fails++;
      $display("FAIL reset_data: addr=%0d data=%h count=%0d required 0 0 0",
               wr_addr, wr_data, count);
    end
    tests++;
    if (err !== 1'b0 || err_addr !== 11'd0) begin
      fails++;
      $display("FAIL reset_err: err=%b err_addr=%0d required 0 0", err, err_addr);
    end
  endtask

  task automatic check_write(input string name, input logic [31:0] exp_data,
                             input logic [10:0] exp_addr, input logic [11:0] exp_count);
    tests++;
    if (wr_en !== 1'b1 || wr_data !== exp_data || wr_addr !== exp_addr) begin
      fails++;
      $display("FAIL %s: wr_en=%b data=%h addr=%0d required 1 %h %0d",
               name, wr_en, wr_data, wr_addr, exp_data, exp_addr);
    end
    @(negedge clk);
    tests++;
    if (wr_en !== 1'b0 || count !== exp_count || wr_addr !== exp_addr + 11'd1) begin
      fails++;
      $display("FAIL %s_commit: wr_en=%b count=%0d addr=%0d required 0 %0d %0d",
               name, wr_en, count, wr_addr, exp_count, exp_addr + 11'd1);
    end
  endtask

  task automatic test_basic;
    wr_ready = 1'b1;
    issue(3'd0, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5);
    check_write("addi", 32'h0050_0093, 11'd0, 12'd1);
    issue(3'd2, 7'h23, 3'd2, 7'h00, 5'd0, 5'd3, 5'd2, 32'hFFFF_FFFC);
    check_write("sw_neg", 32'hFE21_AE23, 11'd1, 12'd2);
  endtask

  task automatic test_formats;
    issue(3'd3, 7'h63, 3'd1, 7'h00, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFF8);
    check_write("bne_neg", 32'hFE20_9CE3, 11'd2, 12'd3);
    issue(3'd4, 7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h1234_5000);
    check_write("lui", 32'h1234_52B7, 11'd3, 12'd4);
    issue(3'd6, 7'h33, 3'd0, 7'h20, 5'd1, 5'd2, 5'd3, 32'hDEAD_BEEF);
    check_write("sub", 32'h4031_00B3, 11'd4, 12'd5);
    issue(3'd1, 7'h13, 3'd5, 7'h20, 5'd1, 5'd2, 5'd0, 32'd3);
    check_write("srai", 32'h4031_5093, 11'd5, 12'd6);
    issue(3'd5, 7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd8);
    check_write("jal", 32'h0080_00EF, 11'd6, 12'd7);
    tests++;
    if (err !== 1'b0) begin
      fails++;
      $display("FAIL no_err_legal: err=%b required 0", err);
    end
  endtask

  task automatic test_error;
    issue(3'd0, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd2048);
    tests++;
    if (err !== ChkEn || err_addr !== (ChkEn ? 11'd7 : 11'd0)) begin
      fails++;
      $display("FAIL err_first: err=%b err_addr=%0d required %b %0d",
               err, err_addr, ChkEn, ChkEn ? 7 : 0);
    end
    check_write("addi_2048", 32'h8000_0093, 11'd7, 12'd8);
    issue(3'd7, 7'h33, 3'd7, 7'h7F, 5'd31, 5'd31, 5'd31, 32'hFFFF_FFFF);
    tests++;
    if (err !== ChkEn || err_addr !== (ChkEn ? 11'd7 : 11'd0)) begin
      fails++;
      $display("FAIL err_sticky: err=%b err_addr=%0d required %b %0d",
               err, err_addr, ChkEn, ChkEn ? 7 : 0);
    end
    check_write("reserved_nop", 32'h0000_0013, 11'd8, 12'd9);
  endtask

  task automatic test_backpressure;
    wr_ready = 1'b0;
    issue(3'd0, 7'h13, 3'd0, 7'h00, 5'd2, 5'd0, 5'd0, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (wr_en !== 1'b1 || wr_addr !== 11'd9 || wr_data !== 32'h0010_0113 ||
          req_ready !== 1'b0 || count !== 12'd9) begin
        fails++;
        $display("FAIL stall_%0d: wr_en=%b addr=%0d data=%h ready=%b count=%0d",
                 i, wr_en, wr_addr, wr_data, req_ready, count);
      end
      @(negedge clk);
    end
    wr_ready = 1'b1;
    check_write("stall_release", 32'h0010_0113, 11'd9, 12'd10);
    @(negedge clk);
    tests++;
    if (wr_addr !== 11'd10 || count !== 12'd10) begin
      fails++;
      $display("FAIL stall_once: addr=%0d count=%0d required 10 10", wr_addr, count);
    end
  endtask

  task automatic test_start;
    wr_ready = 1'b0;
    issue(3'd0, 7'h13, 3'd0, 7'h00, 5'd3, 5'd0, 5'd0, 32'd7);
    start = 1'b1;
    #1;
    tests++;
    if (req_ready !== 1'b0) begin
      fails++;
      $display("FAIL start_ready: ready=%b required 0", req_ready);
    end
    @(negedge clk);
    start = 1'b0;
    tests++;
    if (wr_en !== 1'b0 || busy !== 1'b0 || wr_addr !== 11'd0 || count !== 12'd0 ||
        err !== 1'b0 || err_addr !== 11'd0) begin
      fails++;
      $display("FAIL start_clear: wr_en=%b busy=%b addr=%0d count=%0d err=%b ea=%0d",
               wr_en, busy, wr_addr, count, err, err_addr);
    end
    // start with a same-cycle request: must not be accepted
    start = 1'b1; req_valid = 1'b1;
    @(negedge clk);
    start = 1'b0; req_valid = 1'b0;
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL start_priority: busy=%b required 0", busy);
    end
    wr_ready = 1'b1;
    issue(3'd0, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5);
    check_write("after_start", 32'h0050_0093, 11'd0, 12'd1);
  endtask

  task automatic test_wrap;
    logic [1:0] exp_a [5];
    exp_a = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wr_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      issue(3'd6, 7'h33, 3'd0, 7'h00, 5'(i), 5'd1, 5'd2, 32'd0);
      tests++;
      if (s_wr_en !== 1'b1 || s_wr_addr !== exp_a[i]) begin
        fails++;
        $display("FAIL wrap_addr_%0d: wr_en=%b addr=%0d required 1 %0d",
                 i, s_wr_en, s_wr_addr, exp_a[i]);
      end
    end
    @(negedge clk);
    tests++;
    if (s_count !== 3'd4 || s_wr_addr !== 2'd1) begin
      fails++;
      $display("FAIL wrap_count: count=%0d addr=%0d required 4 1", s_count, s_wr_addr);
    end
  endtask

  task automatic test_async_reset;
    wr_ready = 1'b0;
    issue(3'd0, 7'h13, 3'd0, 7'h00, 5'd4, 5'd0, 5'd0, 32'd9);
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (wr_en !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1 || wr_addr !== 11'd0 ||
        wr_data !== 32'd0 || count !== 12'd0 || err !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: wr_en=%b busy=%b ready=%b addr=%0d data=%h count=%0d",
               wr_en, busy, req_ready, wr_addr, wr_data, count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    wr_ready = 1'b1;
    @(negedge clk);
    tests++;
    if (wr_en !== 1'b0 || count !== 12'd0 || wr_addr !== 11'd0) begin
      fails++;
      $display("FAIL reset_no_write: wr_en=%b count=%0d addr=%0d", wr_en, count, wr_addr);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; req_valid = 1'b0; wr_ready = 1'b0;
    imm_sel = '0; opcode = '0; funct3 = '0; funct7 = '0;
    rd = '0; rs1 = '0; rs2 = '0; imm = '0;
    #12;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_basic();
    test_formats();
    test_error();
    test_backpressure();
    test_start();
    test_wrap();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
